// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: instruction opcodes,
// FSM state encoding, datapath select codes and the control-word bundle.
package multicycle_control_unit_pkg;

    // Instruction opcodes (instruction-register bits [6:0])
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    // Controller states
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    // ALU operand A select
    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_RS1 = 1'b1;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    // Next-PC select
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_ALU    = 2'd1;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

    // Full control word driven to the datapath
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       is_halted;
    } ctrl_t;

    // Opcodes that have an execute phase; anything else is retired from ID
    function automatic logic is_ex_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ARITH, OP_ARITH_IMM,
            OP_BRANCH, OP_JAL, OP_JALR: is_ex_opcode = 1'b1;
            default:                    is_ex_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational control-word decode for the multicycle controller.
// The word is forced to all-zero while the controller is not running, so
// reset and the first cycle after reset never drive a datapath enable.
module control_output_decoder
    import multicycle_control_unit_pkg::*;
(
    input  state_t      state,
    input  logic        enable,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        mem_ready,
    input  logic        ecall_halt,
    output ctrl_t       ctrl
);

    // Decode the datapath controls from the current state and instruction
    always_comb begin
        ctrl = '0;
        if (enable) begin
            case (state)
                S_IF: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b0;
                    ctrl.ir_write = mem_ready;
                end

                S_ID: begin
                    // Branch/jump target is precomputed into ALUOut here
                    ctrl.alu_src_a = SRC_A_PC;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_OP_ADD;
                    if (opcode == OP_ECALL) begin
                        if (!ecall_halt) begin
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PC_SRC_PLUS4;
                        end
                    end else if (!is_ex_opcode(opcode)) begin
                        // Unknown instruction: skip it without side effects
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PC_SRC_PLUS4;
                    end
                end

                S_EX: begin
                    case (opcode)
                        OP_ARITH: begin
                            ctrl.alu_src_a = SRC_A_RS1;
                            ctrl.alu_src_b = SRC_B_RS2;
                            ctrl.alu_op    = ALU_OP_FUNCT;
                        end
                        OP_ARITH_IMM: begin
                            ctrl.alu_src_a = SRC_A_RS1;
                            ctrl.alu_src_b = SRC_B_IMM;
                            ctrl.alu_op    = ALU_OP_FUNCT;
                        end
                        OP_LOAD, OP_STORE: begin
                            ctrl.alu_src_a = SRC_A_RS1;
                            ctrl.alu_src_b = SRC_B_IMM;
                            ctrl.alu_op    = ALU_OP_ADD;
                        end
                        OP_BRANCH: begin
                            ctrl.alu_src_a = SRC_A_RS1;
                            ctrl.alu_src_b = SRC_B_RS2;
                            ctrl.alu_op    = ALU_OP_SUB;
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = bcond ? PC_SRC_ALUOUT : PC_SRC_PLUS4;
                        end
                        OP_JAL: begin
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PC_SRC_ALUOUT;
                        end
                        OP_JALR: begin
                            ctrl.alu_src_a = SRC_A_RS1;
                            ctrl.alu_src_b = SRC_B_IMM;
                            ctrl.alu_op    = ALU_OP_ADD;
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PC_SRC_ALU;
                        end
                        default: begin
                        end
                    endcase
                end

                S_MEM: begin
                    ctrl.i_or_d = 1'b1;
                    if (opcode == OP_LOAD) begin
                        ctrl.mem_read = 1'b1;
                    end else if (opcode == OP_STORE) begin
                        ctrl.mem_write = 1'b1;
                        // Store retires on the completing cycle
                        ctrl.pc_write  = mem_ready;
                        ctrl.pc_source = PC_SRC_PLUS4;
                    end
                end

                S_WB: begin
                    case (opcode)
                        OP_ARITH, OP_ARITH_IMM: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PC_SRC_PLUS4;
                        end
                        OP_LOAD: begin
                            ctrl.reg_write  = 1'b1;
                            ctrl.mem_to_reg = 1'b1;
                            ctrl.pc_write   = 1'b1;
                            ctrl.pc_source  = PC_SRC_PLUS4;
                        end
                        OP_JAL, OP_JALR: begin
                            // Link value PC+4 computed by the ALU; PC already moved in EX
                            ctrl.reg_write = 1'b1;
                            ctrl.alu_src_a = SRC_A_PC;
                            ctrl.alu_src_b = SRC_B_FOUR;
                            ctrl.alu_op    = ALU_OP_ADD;
                        end
                        default: begin
                        end
                    endcase
                end

                S_HALT: begin
                    ctrl.is_halted = 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: state register and sequencing.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IF     | fetch instruction, wait for mem_ready, latch IR
//   ID     | decode, precompute target; ECALL/unknown retire here
//   EX     | ALU operation, branch/jump PC update
//   MEM    | data access for LOAD/STORE, wait for mem_ready
//   WB     | register writeback, PC+4 for ALU/LOAD
//   HALT   | absorbing stop state after ECALL with halt code in x17
//
// A 'running' flag cleared by reset gates the control word so that all
// enables are low while reset is asserted and on the cycle it releases;
// the first rising edge after release starts the fetch.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic [31:0] rf_x17,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        is_halted
);

    state_t state;
    logic   running;
    logic   ecall_halt;
    ctrl_t  ctrl;

    assign ecall_halt = (rf_x17 == HALT_CODE);

    // State register and next-state sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IF;
            running <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            case (state)
                S_IF: begin
                    if (mem_ready) state <= S_ID;
                end
                S_ID: begin
                    if (opcode == OP_ECALL)
                        state <= ecall_halt ? S_HALT : S_IF;
                    else if (is_ex_opcode(opcode))
                        state <= S_EX;
                    else
                        state <= S_IF;
                end
                S_EX: begin
                    case (opcode)
                        OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: state <= S_WB;
                        OP_LOAD, OP_STORE:                       state <= S_MEM;
                        default:                                 state <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        state <= (opcode == OP_LOAD) ? S_WB : S_IF;
                end
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    control_output_decoder u_decoder (
        .state      (state),
        .enable     (running),
        .opcode     (opcode),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .ecall_halt (ecall_halt),
        .ctrl       (ctrl)
    );

    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign i_or_d     = ctrl.i_or_d;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign pc_write   = ctrl.pc_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign is_halted  = ctrl.is_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit.
module tb_multicycle_control_unit;

    localparam logic [6:0] T_LW    = 7'b0000011;
    localparam logic [6:0] T_ADDI  = 7'b0010011;
    localparam logic [6:0] T_SW    = 7'b0100011;
    localparam logic [6:0] T_ADD   = 7'b0110011;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_BEQ   = 7'b1100011;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_ECALL = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        bcond;
    logic [31:0] rf_x17;
    logic        mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_write;
    logic        alu_src_a, is_halted;
    logic [1:0]  alu_src_b, alu_op, pc_source;

    always #5 clk = ~clk;

    multicycle_control_unit #(.HALT_CODE(32'd10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .bcond      (bcond),
        .rf_x17     (rf_x17),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .is_halted  (is_halted)
    );

    // {mem_read,mem_write,i_or_d,ir_write,reg_write,mem_to_reg,pc_write,
    //  alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],is_halted}
    wire [14:0] obs = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg,
                       pc_write, alu_src_a, alu_src_b, alu_op, pc_source, is_halted};

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        bc;
        logic [31:0] x17;
        logic        mrdy;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [14:0] mk(input logic mr, input logic mw, input logic iod,
                                       input logic irw, input logic rw, input logic m2r,
                                       input logic pcw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] pcs,
                                       input logic h);
        return {mr, mw, iod, irw, rw, m2r, pcw, asa, asb, aop, pcs, h};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic bc,
                       input logic [31:0] x, input logic m, input logic [14:0] e);
        vec_t v;
        v.rst_n = r; v.op = op; v.bc = bc; v.x17 = x; v.mrdy = m; v.exp = e;
        vecs.push_back(v);
    endtask

    logic [14:0] o_zero, o_ifw, o_ifr, o_id, o_idpc, o_exi, o_exr, o_exm, o_exb1, o_exb0;
    logic [14:0] o_exj, o_exjr, o_meml, o_mems, o_memsr, o_wba, o_wbl, o_wbj, o_halt;

    initial begin
        //          mr  mw  iod irw rw  m2r pcw asa asb   aop   pcs   h
        o_zero  = '0;
        o_ifw   = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        o_ifr   = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        o_id    = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 0);
        o_idpc  = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 0);
        o_exi   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 0);
        o_exr   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
        o_exm   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
        o_exb1  = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 2'd2, 0);
        o_exb0  = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 2'd0, 0);
        o_exj   = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, 0);
        o_exjr  = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'd2, 2'd0, 2'd1, 0);
        o_meml  = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        o_mems  = mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        o_memsr = mk(0, 1, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        o_wba   = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        o_wbl   = mk(0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        o_wbj   = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
        o_halt  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1);

        // reset held, then released (no enables before the first edge)
        add(0, T_ADDI, 0, 0, 1, o_zero);
        add(1, T_ADDI, 0, 0, 1, o_zero);
        // ADDI: IF ID EX WB
        add(1, T_ADDI, 0, 0, 1, o_ifr);
        add(1, T_ADDI, 0, 0, 1, o_id);
        add(1, T_ADDI, 0, 0, 1, o_exi);
        add(1, T_ADDI, 0, 0, 1, o_wba);
        // LW with two wait cycles in MEM
        add(1, T_LW, 0, 0, 1, o_ifr);
        add(1, T_LW, 0, 0, 1, o_id);
        add(1, T_LW, 0, 0, 1, o_exm);
        add(1, T_LW, 0, 0, 0, o_meml);
        add(1, T_LW, 0, 0, 0, o_meml);
        add(1, T_LW, 0, 0, 1, o_meml);
        add(1, T_LW, 0, 0, 1, o_wbl);
        // BEQ taken, then not taken
        add(1, T_BEQ, 1, 0, 1, o_ifr);
        add(1, T_BEQ, 1, 0, 1, o_id);
        add(1, T_BEQ, 1, 0, 1, o_exb1);
        add(1, T_BEQ, 0, 0, 1, o_ifr);
        add(1, T_BEQ, 0, 0, 1, o_id);
        add(1, T_BEQ, 0, 0, 1, o_exb0);
        // ADD
        add(1, T_ADD, 0, 0, 1, o_ifr);
        add(1, T_ADD, 0, 0, 1, o_id);
        add(1, T_ADD, 0, 0, 1, o_exr);
        add(1, T_ADD, 0, 0, 1, o_wba);
        // JAL, JALR
        add(1, T_JAL, 0, 0, 1, o_ifr);
        add(1, T_JAL, 0, 0, 1, o_id);
        add(1, T_JAL, 0, 0, 1, o_exj);
        add(1, T_JAL, 0, 0, 1, o_wbj);
        add(1, T_JALR, 0, 0, 1, o_ifr);
        add(1, T_JALR, 0, 0, 1, o_id);
        add(1, T_JALR, 0, 0, 1, o_exjr);
        add(1, T_JALR, 0, 0, 1, o_wbj);
        // unknown opcode retires from ID
        add(1, T_LUI, 0, 0, 1, o_ifr);
        add(1, T_LUI, 0, 0, 1, o_idpc);
        // ECALL with non-halt x17, after one fetch wait cycle
        add(1, T_ECALL, 0, 5, 0, o_ifw);
        add(1, T_ECALL, 0, 5, 1, o_ifr);
        add(1, T_ECALL, 0, 5, 1, o_idpc);
        // SW with one wait cycle
        add(1, T_SW, 0, 0, 1, o_ifr);
        add(1, T_SW, 0, 0, 1, o_id);
        add(1, T_SW, 0, 0, 1, o_exm);
        add(1, T_SW, 0, 0, 0, o_mems);
        add(1, T_SW, 0, 0, 1, o_memsr);
        add(1, T_SW, 0, 0, 0, o_ifw);

        reset_n = 1'b0; opcode = T_ADDI; bcond = 1'b0; rf_x17 = '0; mem_ready = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset_n = vecs[i].rst_n; opcode = vecs[i].op; bcond = vecs[i].bc;
            rf_x17 = vecs[i].x17; mem_ready = vecs[i].mrdy;
            #1;
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // SW stalled in MEM, reset pulsed mid-cycle
        @(negedge clk); opcode = T_SW; mem_ready = 1'b1; #1; check("sw_rst_if", obs, o_ifr);
        @(negedge clk); #1; check("sw_rst_id", obs, o_id);
        @(negedge clk); #1; check("sw_rst_ex", obs, o_exm);
        @(negedge clk); mem_ready = 1'b0; #1; check("sw_rst_mem", obs, o_mems);
        #2; reset_n = 1'b0; #1; check("sw_rst_async", obs, o_zero);
        @(negedge clk); reset_n = 1'b1; #1; check("sw_rst_release", obs, o_zero);
        @(negedge clk); #1; check("sw_rst_first_fetch", obs, o_ifw);

        // ECALL with halt code: HALT is sticky
        @(negedge clk); opcode = T_ECALL; rf_x17 = 32'd10; mem_ready = 1'b1; #1;
        check("ecall_if", obs, o_ifr);
        @(negedge clk); #1; check("ecall_id", obs, o_id);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = c[0]; rf_x17 = 32'd5; opcode = (c > 10) ? T_LW : T_ECALL;
            #1; check($sformatf("halt_c%0d", c), obs, o_halt);
        end
        @(negedge clk); reset_n = 1'b0; #1; check("halt_reset", obs, o_zero);
        @(negedge clk); reset_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk); #1; check("halt_refetch", obs, o_ifw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
